// File: rtl/ds18b20_scan_scheduler.sv
// Shares one DS18B20 measurement engine across NUM_CH 1-Wire buses: owns the
// 1 us timebase, scan triggering, bus muxing, conversion timeout and results.
module ds18b20_scan_scheduler #(
   parameter int CLK_DIV         = 50,
   parameter int NUM_CH          = 4,
   parameter int SCAN_PERIOD_MS  = 1000,
   parameter int CONV_TIMEOUT_MS = 1000,
   parameter int GUARD_US        = 1000
) (
   input  logic                     sysclk,
   input  logic                     rst_n,
   input  logic                     trigger,
   output logic                     clk1mhz_en,
   output logic                     meas_start,
   output logic                     eng_rst_n,
   input  logic                     eng_dq_out,
   output logic                     eng_dq_in,
   input  logic                     meas_done,
   input  logic                     meas_ok,
   input  logic [15:0]              eng_temp,
   output logic [NUM_CH-1:0]        bus_dq_out,
   input  logic [NUM_CH-1:0]        bus_dq_in,
   output logic [16*NUM_CH-1:0]     temp_all,
   output logic [NUM_CH-1:0]        valid,
   output logic [NUM_CH-1:0]        err,
   output logic                     busy,
   output logic [2:0]               cur_ch,
   output logic                     scan_done
);

   localparam int PW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int TW       = (CONV_TIMEOUT_MS > 0) ? $clog2(CONV_TIMEOUT_MS + 1) : 1;
   localparam int GW       = (GUARD_US > 0) ? $clog2(GUARD_US + 1) : 1;
   localparam int SW       = (SCAN_PERIOD_MS > 1) ? $clog2(SCAN_PERIOD_MS) : 1;
   localparam int PER_LAST = (SCAN_PERIOD_MS > 0) ? SCAN_PERIOD_MS - 1 : 0;

   typedef enum logic [2:0] {S_IDLE, S_START, S_WAIT, S_STORE, S_GUARD, S_FINISH} state_t;

   state_t          state, state_nx;
   logic [PW-1:0]   presc;
   logic [9:0]      us_cnt;
   logic [SW-1:0]   per_cnt;
   logic [TW-1:0]   to_cnt;
   logic [GW-1:0]   g_cnt;
   logic            pending;
   logic            ok_q;
   logic [15:0]     temp_q;
   logic            ms_tick, auto_req, req, timeout, guard_done, last_ch, to_fire;

   assign clk1mhz_en = (presc == PW'(CLK_DIV - 1));
   assign ms_tick    = clk1mhz_en && (us_cnt == 10'd999);
   assign auto_req   = (SCAN_PERIOD_MS > 0) && ms_tick && (per_cnt == SW'(PER_LAST));
   assign req        = trigger || auto_req;
   assign timeout    = (to_cnt == TW'(CONV_TIMEOUT_MS));
   assign guard_done = (g_cnt == GW'(GUARD_US));
   assign last_ch    = (cur_ch == 3'(NUM_CH - 1));
   assign to_fire    = (state == S_WAIT) && !meas_done && timeout;
   assign busy       = (state != S_IDLE);

   always_ff @(posedge sysclk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nx;
   end

   // A done pulse arriving with the timeout takes priority over the timeout.
   always_comb begin
      state_nx   = state;
      meas_start = 1'b0;
      scan_done  = 1'b0;
      case (state)
         S_IDLE:   if (req || pending) state_nx = S_START;
         S_START: begin
            meas_start = 1'b1;
            state_nx   = S_WAIT;
         end
         S_WAIT: begin
            if (meas_done)    state_nx = S_STORE;
            else if (timeout) state_nx = S_GUARD;
         end
         S_STORE:  state_nx = S_GUARD;
         S_GUARD:  if (guard_done) state_nx = last_ch ? S_FINISH : S_START;
         S_FINISH: begin
            scan_done = 1'b1;
            state_nx  = S_IDLE;
         end
         default:  state_nx = S_IDLE;
      endcase
   end

   // Only the channel under service is connected, and only while a
   // measurement is in flight; the guard interval leaves every bus released.
   always_comb begin
      bus_dq_out = '1;
      eng_dq_in  = 1'b1;
      if (busy && (state == S_START || state == S_WAIT)) begin
         for (int k = 0; k < NUM_CH; k++) begin
            if (cur_ch == 3'(k)) begin
               bus_dq_out[k] = eng_dq_out;
               eng_dq_in     = bus_dq_in[k];
            end
         end
      end
   end

   always_ff @(posedge sysclk or negedge rst_n) begin
      if (!rst_n) begin
         presc     <= '0;
         us_cnt    <= '0;
         per_cnt   <= '0;
         to_cnt    <= '0;
         g_cnt     <= '0;
         pending   <= 1'b0;
         ok_q      <= 1'b0;
         temp_q    <= '0;
         eng_rst_n <= 1'b1;
         cur_ch    <= '0;
         temp_all  <= '0;
         valid     <= '0;
         err       <= '0;
      end else begin
         presc     <= clk1mhz_en ? '0 : presc + 1'b1;
         eng_rst_n <= !to_fire;
         if (clk1mhz_en) us_cnt <= (us_cnt == 10'd999) ? '0 : us_cnt + 10'd1;
         if (ms_tick)    per_cnt <= (per_cnt == SW'(PER_LAST)) ? '0 : per_cnt + 1'b1;

         if (state == S_START)                               to_cnt <= '0;
         else if (state == S_WAIT && ms_tick && !timeout)    to_cnt <= to_cnt + 1'b1;

         if (state != S_GUARD)                   g_cnt <= '0;
         else if (clk1mhz_en && !guard_done)     g_cnt <= g_cnt + 1'b1;

         if (state == S_IDLE) pending <= 1'b0;
         else if (req)        pending <= 1'b1;

         // meas_ok is only meaningful alongside meas_done, so capture it there.
         if (state == S_WAIT && meas_done) begin
            ok_q   <= meas_ok;
            temp_q <= eng_temp;
         end

         if (state == S_IDLE || state == S_FINISH)          cur_ch <= '0;
         else if (state == S_GUARD && guard_done && !last_ch) cur_ch <= cur_ch + 3'd1;

         for (int k = 0; k < NUM_CH; k++) begin
            if (cur_ch == 3'(k)) begin
               if (state == S_STORE) begin
                  if (ok_q) begin
                     temp_all[16*k +: 16] <= temp_q;
                     valid[k]             <= 1'b1;
                     err[k]               <= 1'b0;
                  end else begin
                     err[k] <= 1'b1;
                  end
               end else if (to_fire) begin
                  err[k] <= 1'b1;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_ds18b20_scan_scheduler.sv
// Directed bench for ds18b20_scan_scheduler: a manual-trigger instance driven
// by a scripted engine, plus an auto-scan instance with a self-answering engine.
module tb_ds18b20_scan_scheduler;

   localparam int CLK_DIV = 4;
   localparam int NUM_CH  = 2;

   logic        sysclk = 1'b0;
   logic        rst_n, trigger, eng_dq_out, meas_done, meas_ok;
   logic [15:0] eng_temp;
   logic [1:0]  bus_dq_in;
   logic        clk1mhz_en, meas_start, eng_rst_n, eng_dq_in, busy, scan_done;
   logic [1:0]  bus_dq_out, valid, err;
   logic [31:0] temp_all;
   logic [2:0]  cur_ch;

   logic        a_rst_n, a_meas_done, a_seen;
   logic        a_clk1mhz_en, a_meas_start, a_eng_rst_n, a_eng_dq_in, a_busy, a_scan_done;
   logic [1:0]  a_bus_dq_out, a_valid, a_err;
   logic [31:0] a_temp_all;
   logic [2:0]  a_cur_ch;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc = 0, cnt_start = 0, cnt_done = 0, rst_low = 0;
   int last_start_cyc = 0, last_rst_cyc = 0;
   int start_t[$];
   int a_start_t[$];
   logic a_busy_prev = 1'b0;

   always #5 sysclk = ~sysclk;

   ds18b20_scan_scheduler #(
      .CLK_DIV(CLK_DIV), .NUM_CH(NUM_CH), .SCAN_PERIOD_MS(0),
      .CONV_TIMEOUT_MS(2), .GUARD_US(5)
   ) dut (
      .sysclk(sysclk), .rst_n(rst_n), .trigger(trigger), .clk1mhz_en(clk1mhz_en),
      .meas_start(meas_start), .eng_rst_n(eng_rst_n), .eng_dq_out(eng_dq_out),
      .eng_dq_in(eng_dq_in), .meas_done(meas_done), .meas_ok(meas_ok),
      .eng_temp(eng_temp), .bus_dq_out(bus_dq_out), .bus_dq_in(bus_dq_in),
      .temp_all(temp_all), .valid(valid), .err(err), .busy(busy),
      .cur_ch(cur_ch), .scan_done(scan_done)
   );

   ds18b20_scan_scheduler #(
      .CLK_DIV(CLK_DIV), .NUM_CH(NUM_CH), .SCAN_PERIOD_MS(3),
      .CONV_TIMEOUT_MS(2), .GUARD_US(5)
   ) dut_auto (
      .sysclk(sysclk), .rst_n(a_rst_n), .trigger(1'b0), .clk1mhz_en(a_clk1mhz_en),
      .meas_start(a_meas_start), .eng_rst_n(a_eng_rst_n), .eng_dq_out(1'b1),
      .eng_dq_in(a_eng_dq_in), .meas_done(a_meas_done), .meas_ok(1'b1),
      .eng_temp(16'h1234), .bus_dq_out(a_bus_dq_out), .bus_dq_in(2'b11),
      .temp_all(a_temp_all), .valid(a_valid), .err(a_err), .busy(a_busy),
      .cur_ch(a_cur_ch), .scan_done(a_scan_done)
   );

   // Observers, sampled mid-cycle
   always @(negedge sysclk) begin
      cyc = cyc + 1;
      if (meas_start) begin
         cnt_start      = cnt_start + 1;
         last_start_cyc = cyc;
         start_t.push_back(cyc);
      end
      if (scan_done) cnt_done = cnt_done + 1;
      if (rst_n && !eng_rst_n) begin
         rst_low      = rst_low + 1;
         last_rst_cyc = cyc;
      end
      if (a_busy && !a_busy_prev) a_start_t.push_back(cyc);
      a_busy_prev = a_busy;
   end

   // Auto instance engine: answers every start with a good reading two cycles later
   initial begin
      a_meas_done = 1'b0;
      a_seen      = 1'b0;
      forever begin
         @(negedge sysclk);
         a_meas_done = a_seen;
         a_seen      = a_meas_start;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge sysclk);
   endtask

   task automatic pulse_trigger();
      trigger = 1'b1;
      @(negedge sysclk);
      trigger = 1'b0;
   endtask

   task automatic wait_start(input string tag);
      int n = 0;
      while (!meas_start && n < 20000) begin
         @(negedge sysclk);
         n++;
      end
      check(tag, {31'd0, meas_start}, 32'd1);
   endtask

   task automatic wait_scan_done(input string tag);
      int n = 0;
      while (!scan_done && n < 20000) begin
         @(negedge sysclk);
         n++;
      end
      check(tag, {31'd0, scan_done}, 32'd1);
      tick(1);
   endtask

   task automatic give_done(input logic ok, input logic [15:0] t);
      meas_done = 1'b1;
      meas_ok   = ok;
      eng_temp  = t;
      tick(1);
      meas_done = 1'b0;
      meas_ok   = 1'b0;
      eng_temp  = 16'h0000;
   endtask

   task automatic serve(input string tag, input logic ok, input logic [15:0] t);
      wait_start(tag);
      tick(3);
      give_done(ok, t);
   endtask

   initial begin
      int n_en, last_en, s0, d0, r0, gap, d;
      rst_n = 1'b0; a_rst_n = 1'b0; trigger = 1'b0; eng_dq_out = 1'b1;
      meas_done = 1'b0; meas_ok = 1'b0; eng_temp = 16'h0000; bus_dq_in = 2'b11;
      tick(3);
      check("rst_bus_dq_out", {30'd0, bus_dq_out}, 32'h3);
      check("rst_eng_dq_in", {31'd0, eng_dq_in}, 32'd1);
      check("rst_valid", {30'd0, valid}, 32'd0);
      check("rst_err", {30'd0, err}, 32'd0);
      check("rst_temp_all", temp_all, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_cur_ch", {29'd0, cur_ch}, 32'd0);
      check("rst_outs", {28'd0, meas_start, eng_rst_n, clk1mhz_en, scan_done}, 32'b0100);
      rst_n = 1'b1; a_rst_n = 1'b1;

      // Timebase: 10 pulses in any 40 cycles, spaced by CLK_DIV
      n_en = 0; last_en = -1;
      for (int i = 0; i < 40; i++) begin
         @(negedge sysclk);
         if (clk1mhz_en) begin
            if (last_en >= 0) check("en_gap", i - last_en, CLK_DIV);
            last_en = i;
            n_en++;
         end
      end
      check("en_count", n_en, 10);

      // Normal scan, both channels good
      s0 = cnt_start; d0 = cnt_done;
      pulse_trigger();
      check("t2_busy", {31'd0, busy}, 32'd1);
      serve("t2_ch0_start", 1'b1, 16'h0191);
      serve("t2_ch1_start", 1'b1, 16'hFF5E);
      wait_scan_done("t2_scan_done");
      tick(20);
      check("t2_temp_all", temp_all, {16'hFF5E, 16'h0191});
      check("t2_valid", {30'd0, valid}, 32'h3);
      check("t2_err", {30'd0, err}, 32'd0);
      check("t2_starts", cnt_start - s0, 2);
      check("t2_dones", cnt_done - d0, 1);
      gap = start_t[start_t.size()-1] - start_t[start_t.size()-2];
      check("t2_start_gap_ge_5us", {31'd0, gap >= 5 * CLK_DIV}, 32'd1);
      check("t2_idle_busy", {31'd0, busy}, 32'd0);

      // Bad CRC on ch0 keeps its old reading
      pulse_trigger();
      serve("t3_ch0_start", 1'b0, 16'hDEAD);
      serve("t3_ch1_start", 1'b1, 16'h07D0);
      wait_scan_done("t3_scan_done");
      check("t3_err", {30'd0, err}, 32'h1);
      check("t3_temp_all", temp_all, {16'h07D0, 16'h0191});
      check("t3_valid", {30'd0, valid}, 32'h3);

      // ch1 times out; exercise the bus mux while it waits
      r0 = rst_low;
      pulse_trigger();
      serve("t4_ch0_start", 1'b1, 16'h0550);
      wait_start("t4_ch1_start");
      tick(1);
      bus_dq_in = 2'b01; eng_dq_out = 1'b0;
      #1;
      check("t4_mux_drive_low", {30'd0, bus_dq_out}, 32'h1);
      check("t4_mux_sample_low", {31'd0, eng_dq_in}, 32'd0);
      eng_dq_out = 1'b1;
      #1;
      check("t4_mux_release", {30'd0, bus_dq_out}, 32'h3);
      bus_dq_in = 2'b10;
      #1;
      check("t4_mux_sample_high", {31'd0, eng_dq_in}, 32'd1);
      bus_dq_in = 2'b11;
      wait_scan_done("t4_scan_done");
      check("t4_rst_low_cycles", rst_low - r0, 1);
      d = last_rst_cyc - last_start_cyc;
      check("t4_timeout_window", {31'd0, (d > 1000 * CLK_DIV) && (d <= 2000 * CLK_DIV + 4)}, 32'd1);
      check("t4_err", {30'd0, err}, 32'h2);
      check("t4_temp_all", temp_all, {16'h07D0, 16'h0550});

      // Two triggers during a scan coalesce into one extra scan
      s0 = cnt_start; d0 = cnt_done;
      pulse_trigger();
      wait_start("t5_ch0_start");
      tick(1);
      pulse_trigger();
      tick(1);
      pulse_trigger();
      give_done(1'b1, 16'h0011);
      serve("t5_ch1_start", 1'b1, 16'h0022);
      serve("t5_rescan_ch0", 1'b1, 16'h0033);
      serve("t5_rescan_ch1", 1'b1, 16'h0044);
      wait_scan_done("t5_scan_done");
      tick(300);
      check("t5_starts", cnt_start - s0, 4);
      check("t5_dones", cnt_done - d0, 2);
      check("t5_busy", {31'd0, busy}, 32'd0);
      check("t5_temp_all", temp_all, {16'h0044, 16'h0033});

      // Asynchronous reset in the middle of WAIT
      pulse_trigger();
      wait_start("t6_start");
      tick(1);
      eng_dq_out = 1'b0;
      #1;
      check("t6_pre_drive", {30'd0, bus_dq_out}, 32'h2);
      rst_n = 1'b0;
      #1;
      check("t6_bus_released", {30'd0, bus_dq_out}, 32'h3);
      check("t6_busy", {31'd0, busy}, 32'd0);
      check("t6_valid", {30'd0, valid}, 32'd0);
      check("t6_temp_all", temp_all, 32'd0);
      eng_dq_out = 1'b1;
      tick(2);
      rst_n = 1'b1;

      // Auto instance: scans every 3 ms with no trigger
      for (int i = 0; i < 40000 && a_start_t.size() < 3; i++) @(negedge sysclk);
      check("auto_scan_count", {31'd0, a_start_t.size() >= 3}, 32'd1);
      if (a_start_t.size() >= 3) begin
         check("auto_period_1", a_start_t[1] - a_start_t[0], 3000 * CLK_DIV);
         check("auto_period_2", a_start_t[2] - a_start_t[1], 3000 * CLK_DIV);
      end
      tick(200);
      check("auto_temp_all", a_temp_all, {16'h1234, 16'h1234});
      check("auto_valid", {30'd0, a_valid}, 32'h3);
      check("auto_err", {30'd0, a_err}, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/ds18b20_scan_scheduler.md
Name: ds18b20_scan_scheduler

Overview:
- Sequences one shared DS18B20 measurement engine across NUM_CH independent 1-Wire buses.
- Sits between the engine and the sensor pins, and owns all of the following:
  - the 1 µs enable (clk1mhz_en);
  - periodic or manual scan triggering;
  - per-channel bus multiplexing;
  - conversion timeout;
  - per-channel result and error registers.
- Channels are scanned in ascending order, one measurement at a time.

Parameters:
- CLK_DIV, 50, sysclk cycles per 1 µs enable pulse (≥2).
- NUM_CH, 4, number of 1-Wire buses (1..8).
- SCAN_PERIOD_MS, 1000, ms between automatic scan starts; 0 disables auto scan.
- CONV_TIMEOUT_MS, 1000, maximum ms from meas_start to meas_done per channel.
- GUARD_US, 1000, idle µs with all buses released between channels.

Ports:
- sysclk, in, 1, system clock.
- rst_n, in, 1, asynchronous active-low reset.
- trigger, in, 1, manual scan request (one-cycle pulse).
- clk1mhz_en, out, 1, one-cycle pulse every CLK_DIV sysclk cycles, to engine.
- meas_start, out, 1, one-cycle start pulse to engine.
- eng_rst_n, out, 1, engine reset; low for exactly one cycle on timeout.
- eng_dq_out, in, 1, engine drive value.
- eng_dq_in, out, 1, muxed bus sample to engine.
- meas_done, in, 1, engine one-cycle completion pulse.
- meas_ok, in, 1, CRC good; qualified by meas_done.
- eng_temp, in, 16, engine raw temperature word.
- bus_dq_out, out, NUM_CH, per-bus drive (1 = released).
- bus_dq_in, in, NUM_CH, per-bus sampled level.
- temp_all, out, 16*NUM_CH, channel k at [16k+15:16k].
- valid, out, NUM_CH, channel holds at least one good reading.
- err, out, NUM_CH, last attempt failed (CRC or timeout).
- busy, out, 1, scan in progress.
- cur_ch, out, 3, channel under service.
- scan_done, out, 1, one-cycle pulse at end of scan.

Behaviour:
- Reset values:
  - bus_dq_out = all 1; eng_dq_in = 1.
  - meas_start = 0; eng_rst_n = 1; clk1mhz_en = 0.
  - temp_all = 0; valid = 0; err = 0.
  - busy = 0; cur_ch = 0; scan_done = 0.
  - All counters = 0; pending = 0.
- Timebase:
  - Prescaler counts 0..CLK_DIV-1; clk1mhz_en = 1 when count == CLK_DIV-1. Free-running, never gated.
  - A µs counter (0..999) derives a ms tick.
  - A period counter counts ms ticks; its wrap at SCAN_PERIOD_MS-1 produces an auto request.
- Bus mux:
  - When busy is high and state is START or WAIT: bus_dq_out[cur_ch] = eng_dq_out, and eng_dq_in = bus_dq_in[cur_ch].
  - All other bus bits = 1; otherwise eng_dq_in = 1. Combinational path.
- FSM states: IDLE, START, WAIT, STORE, GUARD, FINISH.
  - IDLE: on trigger, auto request, or pending → cur_ch = 0, busy = 1, clear pending → START.
  - START: meas_start = 1 for one cycle; clear timeout ms counter → WAIT.
  - WAIT:
    - On meas_done → STORE.
    - Else, when the timeout counter reaches CONV_TIMEOUT_MS: set err[cur_ch], pulse eng_rst_n low for one cycle → GUARD.
  - STORE (1 cycle):
    - If meas_ok: latch eng_temp into the cur_ch slot, set valid[cur_ch], clear err[cur_ch].
    - Else: set err[cur_ch]; temp and valid unchanged.
    - → GUARD.
  - GUARD:
    - Count GUARD_US clk1mhz_en pulses.
    - Then, if cur_ch == NUM_CH-1 → FINISH; else increment cur_ch → START.
  - FINISH: scan_done = 1 for one cycle; busy = 0; cur_ch = 0 → IDLE.
- Simultaneous and overlapping events:
  - A trigger or auto request while busy sets pending (depth 1, further requests coalesce). Pending starts a new scan from IDLE on the cycle after FINISH.
  - meas_done in the same cycle as the timeout is treated as done (done wins).
  - meas_done outside WAIT is ignored.
  - The period counter keeps running during scans.
- Reset mid-scan: all buses are released immediately (async), and the register file clears.
- Width rules:
  - The timeout counter is ≥ clog2(CONV_TIMEOUT_MS+1) bits.
  - temp_all stores the raw two's-complement word unmodified (1/16 °C LSB).

Test Plan:
- Sim parameters: CLK_DIV=4, NUM_CH=2, SCAN_PERIOD_MS=0, CONV_TIMEOUT_MS=2, GUARD_US=5.
- Reset → clk1mhz_en pulses every 4 cycles; bus_dq_out = 2'b11; valid = 0; busy = 0.
- Trigger; engine model answers meas_done & meas_ok with eng_temp = 16'h0191 (ch0), then 16'hFF5E (ch1) → temp_all = {16'hFF5E, 16'h0191}; valid = 2'b11; err = 0; one scan_done pulse; exactly 2 meas_start pulses ≥ 5 µs apart.
- ch0 meas_done with meas_ok = 0 → err = 2'b01; ch0 temp retains its prior value; ch1 updates normally.
- ch1 never returns done → after 2 ms, err[1] = 1, eng_rst_n low exactly 1 cycle, then FINISH and scan_done.
- During WAIT on ch1, force bus_dq_in = 2'b01 and toggle eng_dq_out → only bus_dq_out[1] follows; bus_dq_out[0] = 1; eng_dq_in = 0.
- Two triggers mid-scan → exactly one extra scan follows; SCAN_PERIOD_MS = 3 → auto scans start every 3 ms with no trigger.
- Assert rst_n low during WAIT → bus_dq_out = all 1 and busy = 0 with no clock edge.
